frame_loader: RTL and testbench

//  Upstream front-end of the CNN accelerator core. Accepts a byte stream over
//  a valid/ready handshake and buffers it in an internal FIFO. Drives the

---
 rtl/frame_loader.sv | 186 ++++++++++++++++++
 tb/tb_frame_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_loader.sv
// Byte-stream front-end for the CNN core: buffers upstream bytes, then feeds weights and 8x8 image bursts.
// Optional frame counter and overflow flag are enabled by defining FRAME_LOADER_FRAME_CNT_EN.
module frame_loader #(
  parameter int unsigned WGT_BYTES  = 54,
  parameter int unsigned IMG_BYTES  = 64,
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       reload_w,
  input  logic       out_data_flag,
  output logic       mode,
  output logic       ram_en,
  output logic [7:0] din,
  output logic       busy
`ifdef FRAME_LOADER_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt,
  output logic       ovf_err
`endif
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BCNT_W = $clog2(IMG_BYTES + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    FILL,
    LOAD_D,
    WAIT_OUT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_post;
  logic [BCNT_W-1:0] byte_cnt;
  logic              w_pend;
  logic              push;
  logic              pop;
  logic              clr_w;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign s_ready    = (count < CNT_W'(FIFO_DEPTH));
  assign push       = s_valid && s_ready;
  assign busy       = (state != IDLE);
  // Occupancy after a weight pop, including a push landing in the same cycle.
  assign count_post = count - CNT_W'(1) + CNT_W'(push);

  // Next-state and pop control.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    clr_w     = 1'b0;
    case (state)
      IDLE: begin
        if (w_pend && (count != '0)) begin
          state_nxt = LOAD_W;
        end else if (!w_pend && (count >= CNT_W'(IMG_BYTES))) begin
          state_nxt = LOAD_D;
        end
      end
      LOAD_W: begin
        if (count != '0) begin
          pop = 1'b1;
          if (byte_cnt == BCNT_W'(WGT_BYTES - 1)) begin
            clr_w     = 1'b1;
            state_nxt = (count_post >= CNT_W'(IMG_BYTES)) ? LOAD_D : FILL;
          end
        end
      end
      FILL: begin
        if (count >= CNT_W'(IMG_BYTES)) begin
          state_nxt = LOAD_D;
        end
      end
      LOAD_D: begin
        pop = 1'b1;
        if (byte_cnt == BCNT_W'(IMG_BYTES - 1)) begin
          state_nxt = WAIT_OUT;
        end
      end
      WAIT_OUT: begin
        if (out_data_flag) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; byte counter restarts on every state entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      byte_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        byte_cnt <= '0;
      end else if (pop) begin
        byte_cnt <= byte_cnt + BCNT_W'(1);
      end
    end
  end

  // A reload request wins over the clear from the final weight pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_pend <= 1'b1;
    end else if (reload_w) begin
      w_pend <= 1'b1;
    end else if (clr_w) begin
      w_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Core-side strobes; mode and din hold between writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_en <= 1'b0;
      mode   <= 1'b0;
      din    <= 8'd0;
    end else begin
      ram_en <= pop;
      if (pop) begin
        mode <= (state == LOAD_W);
        din  <= mem[rd_ptr];
      end
    end
  end

`ifdef FRAME_LOADER_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= 8'd0;
      ovf_err   <= 1'b0;
    end else begin
      if ((state == LOAD_D) && (state_nxt == WAIT_OUT)) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (s_valid && !s_ready) begin
        ovf_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_frame_loader.sv
// Scoreboard bench for frame_loader: driver queues expected core writes, monitor checks every strobe.
module tb_frame_loader;

  localparam int WGT = 54;
  localparam int IMG = 64;

  logic       clk;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       reload_w;
  logic       out_data_flag;
  logic       mode;
  logic       ram_en;
  logic [7:0] din;
  logic       busy;
`ifdef FRAME_LOADER_FRAME_CNT_EN
  logic [7:0] frame_cnt;
  logic       ovf_err;
`endif

  frame_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .reload_w      (reload_w),
    .out_data_flag (out_data_flag),
    .mode          (mode),
    .ram_en        (ram_en),
    .din           (din),
    .busy          (busy)
`ifdef FRAME_LOADER_FRAME_CNT_EN
    ,
    .frame_cnt     (frame_cnt),
    .ovf_err       (ovf_err)
`endif
  );

  typedef struct packed {
    logic       m;
    logic [7:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   data_run = 0;
  int   frames_done = 0;
  int   frames_since_rst = 0;
  bit   frame_allowed = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every core write must match the next queued byte and mode; image bursts must be gap-free.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        data_run = 0;
        frame_allowed = 1'b1;
        frames_since_rst = 0;
      end else if (ram_en) begin
        if (!frame_allowed) begin
          n_tests++;
          n_fail++;
          $display("FAIL strobe_before_flag: got ram_en=1 expected 0");
        end
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_strobe: got din=%0h with empty queue expected no write", din);
        end else begin
          e = exp_q.pop_front();
          check("write_mode", 32'(mode), 32'(e.m));
          check("write_din", 32'(din), 32'(e.d));
        end
        if (mode == 1'b0) begin
          data_run++;
          if (data_run == IMG) begin
            data_run = 0;
            frames_done++;
            frames_since_rst++;
            frame_allowed = 1'b0;
          end
        end else if (data_run != 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL burst_mode_switch: got mode=1 at burst byte %0d expected 0", data_run);
          data_run = 0;
        end
      end else if (data_run != 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL burst_gap: got ram_en=0 at burst byte %0d expected 1", data_run);
        data_run = 0;
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, input logic m);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = b;
    @(negedge clk);
    while (!s_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: got s_ready=0 expected 1");
      s_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back({m, b});
      #1;
      s_valid = 1'b0;
    end
  endtask

  task automatic send_bytes(input int n, input logic m, input int gmin, input int gmax);
    int g;
    for (int i = 0; i < n; i++) begin
      push_byte(8'($urandom), m);
      g = int'($urandom_range(gmax, gmin));
      repeat (g) @(posedge clk);
      if (g > 0) #1;
    end
  endtask

  task automatic send_frame(input bit with_w, input int gmin, input int gmax);
    if (with_w) send_bytes(WGT, 1'b1, gmin, gmax);
    send_bytes(IMG, 1'b0, gmin, gmax);
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (frames_done < target && t < 3000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("frame_done_count", 32'(frames_done), 32'(target));
  endtask

  task automatic wait_run(input int n);
    int t;
    t = 0;
    while (data_run != n && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("burst_position", 32'(data_run), 32'(n));
  endtask

  task automatic pulse_flag();
    @(posedge clk);
    #1;
    out_data_flag = 1'b1;
    frame_allowed = 1'b1;
    @(posedge clk);
    #1;
    out_data_flag = 1'b0;
  endtask

  task automatic pulse_reload();
    @(posedge clk);
    #1;
    reload_w = 1'b1;
    @(posedge clk);
    #1;
    reload_w = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    s_valid       = 1'b0;
    s_data        = 8'd0;
    reload_w      = 1'b0;
    out_data_flag = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_din", 32'(din), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
`ifdef FRAME_LOADER_FRAME_CNT_EN
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_ovf_err", 32'(ovf_err), 32'd0);
`endif

    // Weights plus image, streamed back-to-back.
    send_frame(1'b1, 0, 0);
    wait_done(1);
    repeat (5) @(posedge clk);
    #1;
    check("wait_out_busy", 32'(busy), 32'd1);
    check("wait_out_ram_en", 32'(ram_en), 32'd0);

    // Image-only frame buffered during WAIT_OUT; must not start before the flag.
    send_frame(1'b0, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    check("held_busy", 32'(busy), 32'd1);
    pulse_flag();
    wait_done(2);

    // Trickle input: one byte every third cycle.
    pulse_flag();
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);
    send_frame(1'b0, 2, 2);
    wait_done(3);

    // reload_w during a burst: burst unaffected, next frame reloads weights.
    pulse_flag();
    send_frame(1'b0, 0, 1);
    wait_run(10);
    pulse_reload();
    wait_done(4);
    pulse_flag();
    send_frame(1'b1, 0, 2);
    wait_done(5);

    // Reset at byte 30 of a burst drops everything buffered.
    pulse_flag();
    send_frame(1'b0, 0, 0);
    wait_run(30);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_ram_en", 32'(ram_en), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd1);
    send_frame(1'b1, 0, 0);
    wait_done(6);

    // Fill the FIFO during WAIT_OUT and keep pushing: backpressure, no byte lost.
    send_frame(1'b0, 0, 0);
    fork
      push_byte(8'($urandom), 1'b0);
      begin
        repeat (4) @(posedge clk);
        #1;
        check("full_s_ready", 32'(s_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        pulse_flag();
      end
    join
    wait_done(7);
    send_bytes(IMG - 1, 1'b0, 0, 1);
    pulse_flag();
    wait_done(8);
`ifdef FRAME_LOADER_FRAME_CNT_EN
    check("ovf_err_sticky", 32'(ovf_err), 32'd1);
    check("frame_cnt", 32'(frame_cnt), 32'(frames_since_rst));
`endif

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_ram_en", 32'(ram_en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
